// File: rtl/nn_layer_sequencer.sv
// rtl/nn_layer_sequencer.sv - two-layer inference sequencer driving sigmoid_ALU
// Walks 8 hidden neurons over 36 image rows, then 10 output neurons over the stored hidden activations.
module nn_layer_sequencer #(
  parameter int N_HIDDEN = 8,
  parameter int N_OUTPUT = 10,
  parameter int IMG_ROWS = 36,
  parameter int ALU_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [5:0]  img_addr,
  input  logic [15:0] img_row,
  output logic [8:0]  w_addr,
  input  logic [15:0] w_row,
  output logic [4:0]  b_addr,
  input  logic [3:0]  b_data,
  output logic [15:0] alu_weights,
  output logic [15:0] alu_inputs,
  output logic [3:0]  alu_bias,
  output logic        alu_clear,
  output logic        alu_accumulate,
  input  logic [3:0]  alu_out,
  output logic        busy,
  output logic        done,
  output logic [3:0]  digit,
  output logic        digit_valid
);
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_LOAD, S_WAIT, S_ACCUM, S_CAPTURE, S_DONE
  } state_t;

  localparam logic [3:0] LAST_HID     = 4'(N_HIDDEN - 1);
  localparam logic [3:0] LAST_OUT     = 4'(N_OUTPUT - 1);
  localparam logic [5:0] LAST_ROW_HID = 6'(IMG_ROWS - 1);
  localparam logic [5:0] LAST_ROW_OUT = 6'd1;
  localparam logic [1:0] LAST_WAIT    = 2'(ALU_LAT - 1);
  localparam logic [8:0] ROWS_9       = 9'(IMG_ROWS);
  localparam logic [8:0] W_OUT_BASE   = 9'(N_HIDDEN * IMG_ROWS);
  localparam logic [4:0] B_OUT_BASE   = 5'(N_HIDDEN);

  state_t                state_q, state_d;
  logic                  layer_q, layer_d;
  logic [3:0]            neuron_q, neuron_d;
  logic [5:0]            row_q, row_d;
  logic [1:0]            wait_cnt_q, wait_cnt_d;
  logic [N_HIDDEN*4-1:0] h_q, h_d;
  logic [3:0]            max_q, max_d, idx_q, idx_d;
  logic [3:0]            digit_q, digit_d;
  logic                  digit_valid_q, digit_valid_d;
  logic [5:0]            img_addr_q, img_addr_d;
  logic [8:0]            w_addr_q, w_addr_d;
  logic [4:0]            b_addr_q, b_addr_d;
  logic [15:0]           alu_weights_q, alu_weights_d;
  logic [15:0]           alu_inputs_q, alu_inputs_d;
  logic [3:0]            alu_bias_q, alu_bias_d;
  logic                  last_row;

  assign last_row = (row_q == (layer_q ? LAST_ROW_OUT : LAST_ROW_HID));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      layer_q       <= 1'b0;
      neuron_q      <= '0;
      row_q         <= '0;
      wait_cnt_q    <= '0;
      h_q           <= '0;
      max_q         <= '0;
      idx_q         <= '0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      img_addr_q    <= '0;
      w_addr_q      <= '0;
      b_addr_q      <= '0;
      alu_weights_q <= '0;
      alu_inputs_q  <= '0;
      alu_bias_q    <= '0;
    end else begin
      state_q       <= state_d;
      layer_q       <= layer_d;
      neuron_q      <= neuron_d;
      row_q         <= row_d;
      wait_cnt_q    <= wait_cnt_d;
      h_q           <= h_d;
      max_q         <= max_d;
      idx_q         <= idx_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      img_addr_q    <= img_addr_d;
      w_addr_q      <= w_addr_d;
      b_addr_q      <= b_addr_d;
      alu_weights_q <= alu_weights_d;
      alu_inputs_q  <= alu_inputs_d;
      alu_bias_q    <= alu_bias_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CLEAR;
      S_CLEAR:   state_d = S_FETCH;
      S_FETCH:   state_d = S_LOAD;
      S_LOAD:    state_d = S_WAIT;
      S_WAIT:    if (wait_cnt_q == LAST_WAIT) state_d = S_ACCUM;
      S_ACCUM:   state_d = last_row ? S_CAPTURE : S_FETCH;
      S_CAPTURE: state_d = (layer_q && neuron_q == LAST_OUT) ? S_DONE : S_CLEAR;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    layer_d       = layer_q;
    neuron_d      = neuron_q;
    row_d         = row_q;
    wait_cnt_d    = wait_cnt_q;
    h_d           = h_q;
    max_d         = max_q;
    idx_d         = idx_q;
    digit_d       = digit_q;
    digit_valid_d = digit_valid_q;
    img_addr_d    = img_addr_q;
    w_addr_d      = w_addr_q;
    b_addr_d      = b_addr_q;
    alu_weights_d = alu_weights_q;
    alu_inputs_d  = alu_inputs_q;
    alu_bias_d    = alu_bias_q;
    case (state_q)
      S_IDLE: if (start) begin
        layer_d       = 1'b0;
        neuron_d      = '0;
        h_d           = '0;
        max_d         = '0;
        idx_d         = '0;
        digit_d       = '0;
        digit_valid_d = 1'b0;
      end
      S_CLEAR: row_d = '0;
      // Bias was addressed in CLEAR, so it arrives during the neuron's first FETCH.
      S_FETCH: if (row_q == '0) alu_bias_d = b_data;
      S_LOAD: begin
        alu_weights_d = w_row;
        alu_inputs_d  = layer_q ? (row_q[0] ? h_q[31:16] : h_q[15:0]) : img_row;
        wait_cnt_d    = '0;
      end
      S_WAIT:  wait_cnt_d = wait_cnt_q + 2'd1;
      S_ACCUM: if (!last_row) row_d = row_q + 6'd1;
      S_CAPTURE: begin
        if (!layer_q) begin
          h_d[{neuron_q[2:0], 2'b00} +: 4] = alu_out;
          if (neuron_q == LAST_HID) begin
            layer_d  = 1'b1;
            neuron_d = '0;
          end else begin
            neuron_d = neuron_q + 4'd1;
          end
        end else begin
          // Strict compare so a tie keeps the lower neuron index.
          if (alu_out > max_q) begin
            max_d = alu_out;
            idx_d = neuron_q;
          end
          if (neuron_q != LAST_OUT) neuron_d = neuron_q + 4'd1;
        end
      end
      default: ;
    endcase

    // Addresses are registered on entry so they are stable for the whole target state.
    if (state_d == S_CLEAR)
      b_addr_d = layer_d ? (B_OUT_BASE + {1'b0, neuron_d}) : {1'b0, neuron_d};
    if (state_d == S_FETCH) begin
      img_addr_d = row_d;
      w_addr_d   = layer_d ? (W_OUT_BASE + {4'd0, neuron_d, 1'b0} + {8'd0, row_d[0]})
                           : ({5'd0, neuron_d} * ROWS_9 + {3'd0, row_d});
    end
    if (state_d == S_DONE) begin
      digit_d       = idx_d;
      digit_valid_d = 1'b1;
    end
  end

  always_comb begin
    alu_clear      = (state_q == S_CLEAR);
    alu_accumulate = (state_q == S_ACCUM);
    busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    done           = (state_q == S_DONE);
  end

  assign img_addr    = img_addr_q;
  assign w_addr      = w_addr_q;
  assign b_addr      = b_addr_q;
  assign alu_weights = alu_weights_q;
  assign alu_inputs  = alu_inputs_q;
  assign alu_bias    = alu_bias_q;
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb/tb_nn_layer_sequencer.sv - self-checking bench for nn_layer_sequencer
// ROM and ALU models feed the DUT; a cycle-offset model predicts every output.
module tb_nn_layer_sequencer;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [5:0]  img_addr;
  logic [15:0] img_row;
  logic [8:0]  w_addr;
  logic [15:0] w_row;
  logic [4:0]  b_addr;
  logic [3:0]  b_data;
  logic [15:0] alu_weights, alu_inputs;
  logic [3:0]  alu_bias;
  logic        alu_clear, alu_accumulate;
  logic [3:0]  alu_out;
  logic        busy, done;
  logic [3:0]  digit;
  logic        digit_valid;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [15:0] img_mem [36];
  logic [15:0] w_mem [308];
  logic [3:0]  b_mem [18];
  int alu_acc;

  int model_h [8];
  int exp_digit, lit_digit, t0;
  bit lit_pack, run_active, dv_expect;

  int acc_cnt, clr_cnt;
  bit rst_prev = 1'b0;
  int ck, cn, cj, cr, cp, last_j, wa, bi;
  bit hid, e_busy, e_done, e_clr, e_acc;

  nn_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .img_addr(img_addr), .img_row(img_row),
    .w_addr(w_addr), .w_row(w_row),
    .b_addr(b_addr), .b_data(b_data),
    .alu_weights(alu_weights), .alu_inputs(alu_inputs), .alu_bias(alu_bias),
    .alu_clear(alu_clear), .alu_accumulate(alu_accumulate), .alu_out(alu_out),
    .busy(busy), .done(done), .digit(digit), .digit_valid(digit_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Signed 4-bit weights times unsigned 4-bit inputs, four lanes.
  function automatic int dot(input logic [15:0] w, input logic [15:0] x);
    int s = 0;
    for (int i = 0; i < 4; i++)
      s += int'($signed(w[4*i +: 4])) * int'(x[4*i +: 4]);
    return s;
  endfunction

  function automatic int act(input int acc, input logic [3:0] b);
    int v = (acc >>> 4) + int'(b);
    if (v < 0) v = 0;
    if (v > 15) v = 15;
    return v;
  endfunction

  function automatic logic [15:0] hpack(input int half);
    logic [15:0] p = '0;
    for (int i = 0; i < 4; i++) p[4*i +: 4] = 4'(model_h[4*half + i]);
    return p;
  endfunction

  always @(posedge clk) begin
    img_row <= (int'(img_addr) < 36)  ? img_mem[int'(img_addr)] : 16'h0;
    w_row   <= (int'(w_addr)   < 308) ? w_mem[int'(w_addr)]     : 16'h0;
    b_data  <= (int'(b_addr)   < 18)  ? b_mem[int'(b_addr)]     : 4'h0;
  end

  always @(posedge clk) begin
    if (rst || alu_clear) alu_acc <= 0;
    else if (alu_accumulate) alu_acc <= alu_acc + dot(alu_weights, alu_inputs);
  end
  assign alu_out = 4'(act(alu_acc, alu_bias));

  task automatic chk(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act_v, exp_v, cyc);
    end
  endtask

  task automatic compute_model();
    int acc, o, best;
    for (int n = 0; n < 8; n++) begin
      acc = 0;
      for (int r = 0; r < 36; r++) acc += dot(w_mem[n*36 + r], img_mem[r]);
      model_h[n] = act(acc, b_mem[n]);
    end
    best = 0;
    exp_digit = 0;
    for (int n = 0; n < 10; n++) begin
      acc = dot(w_mem[288 + 2*n], hpack(0)) + dot(w_mem[289 + 2*n], hpack(1));
      o = act(acc, b_mem[8 + n]);
      if (o > best) begin
        best = o;
        exp_digit = n;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      rst_prev = 1'b1;
    end else begin
      if (rst_prev) begin
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_accumulate", int'(alu_accumulate), 0);
        chk("rst_clear", int'(alu_clear), 0);
        chk("rst_img_addr", int'(img_addr), 0);
        chk("rst_w_addr", int'(w_addr), 0);
        chk("rst_b_addr", int'(b_addr), 0);
        chk("rst_alu_weights", int'(alu_weights), 0);
        chk("rst_alu_inputs", int'(alu_inputs), 0);
        chk("rst_alu_bias", int'(alu_bias), 0);
        chk("rst_digit", int'(digit), 0);
        chk("rst_digit_valid", int'(digit_valid), 0);
      end
      rst_prev = 1'b0;
      e_busy = 0; e_done = 0; e_clr = 0; e_acc = 0;
      ck = run_active ? (cyc - t0) : -1;
      if (ck == 0) begin
        acc_cnt = 0;
        clr_cnt = 0;
      end
      if (ck >= 1 && ck <= 1576) begin
        e_busy = 1;
        hid    = (ck <= 1456);
        cn     = hid ? (ck - 1) / 182 : (ck - 1457) / 12;
        cj     = hid ? (ck - 1) % 182 : (ck - 1457) % 12;
        last_j = hid ? 181 : 11;
        if (cj == 0) begin
          e_clr = 1;
          chk("b_addr", int'(b_addr), hid ? cn : 8 + cn);
        end else if (cj < last_j) begin
          cr = (cj - 1) / 5;
          cp = (cj - 1) % 5;
          wa = hid ? cn*36 + cr : 288 + 2*cn + cr;
          bi = hid ? cn : 8 + cn;
          if (cp == 0) begin
            chk("w_addr", int'(w_addr), wa);
            if (hid) chk("img_addr", int'(img_addr), cr);
          end
          if (cp >= 2) begin
            chk("alu_weights", int'(alu_weights), int'(w_mem[wa]));
            chk("alu_inputs", int'(alu_inputs), hid ? int'(img_mem[cr]) : int'(hpack(cr)));
            chk("alu_bias", int'(alu_bias), int'(b_mem[bi]));
          end
          if (cp == 4) e_acc = 1;
        end
        chk("digit_valid_busy", int'(digit_valid), 0);
      end
      if (ck == 1577) begin
        e_done = 1;
        chk("digit", int'(digit), exp_digit);
        if (lit_digit >= 0) chk("digit_literal", int'(digit), lit_digit);
        chk("digit_valid_done", int'(digit_valid), 1);
        chk("accumulate_pulses", acc_cnt, 308);
        chk("clear_pulses", clr_cnt, 18);
      end
      if (lit_pack && ck == 1462) chk("out_inputs_half0", int'(alu_inputs), 32'h4321);
      if (lit_pack && ck == 1467) chk("out_inputs_half1", int'(alu_inputs), 32'h8765);
      if (!run_active) begin
        if (dv_expect) begin
          chk("digit_valid_hold", int'(digit_valid), 1);
          chk("digit_hold", int'(digit), exp_digit);
        end else begin
          chk("digit_valid_idle", int'(digit_valid), 0);
        end
      end
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("alu_clear", int'(alu_clear), int'(e_clr));
      chk("alu_accumulate", int'(alu_accumulate), int'(e_acc));
      if (alu_accumulate) acc_cnt++;
      if (alu_clear) clr_cnt++;
    end
  end

  task automatic clear_params();
    for (int i = 0; i < 308; i++) w_mem[i] = 16'h0;
    for (int i = 0; i < 18; i++) b_mem[i] = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at #1 after a rising edge while the DUT is idle; start is presented in this cycle (offset 0).
  task automatic run(input int lit_d, input bit lit_p, input int abort_k, input bit extra);
    lit_digit  = lit_d;
    lit_pack   = lit_p;
    start      = 1'b1;
    t0         = cyc;
    run_active = 1'b1;
    compute_model();
    dv_expect  = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 1577; k++) begin
      start = extra && (k == 10 || k == 1000);
      if (k == abort_k) rst = 1'b1;
      @(posedge clk);
      #1;
      if (rst) begin
        rst        = 1'b0;
        start      = 1'b0;
        run_active = 1'b0;
        return;
      end
    end
    start      = 1'b0;
    run_active = 1'b0;
    dv_expect  = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    run_active = 1'b0; dv_expect = 1'b0; lit_pack = 1'b0;
    lit_digit = -1; t0 = 0; exp_digit = 0; alu_acc = 0;
    acc_cnt = 0; clr_cnt = 0;
    for (int r = 0; r < 36; r++)
      for (int i = 0; i < 4; i++) img_mem[r][4*i +: 4] = 4'((r + 5*i) % 16);
    clear_params();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // All parameters zero: every activation 0, digit 0.
    run(0, 1'b0, -1, 1'b0);
    idle(3);

    // Hidden activations 3; output neuron 7 gets max positive weights.
    for (int n = 0; n < 8; n++) b_mem[n] = 4'd3;
    w_mem[288 + 14] = 16'h7777;
    w_mem[289 + 14] = 16'h7777;
    run(7, 1'b0, -1, 1'b0);
    idle(2);
    w_mem[288 + 6] = 16'h7777;
    w_mem[289 + 6] = 16'h7777;
    run(3, 1'b0, -1, 1'b0);
    idle(2);

    // Hidden activations 1..8; neuron 9 wins through its upper-half weights.
    clear_params();
    for (int n = 0; n < 8; n++) b_mem[n] = 4'(n + 1);
    for (int n = 0; n < 10; n++) w_mem[288 + 2*n] = {4{4'(n % 8)}};
    w_mem[289 + 18] = 16'h7777;
    run(9, 1'b1, -1, 1'b0);
    idle(2);

    // Mixed signed weights and biases.
    for (int n = 0; n < 8; n++) begin
      b_mem[n] = 4'(n);
      for (int r = 0; r < 36; r++)
        for (int i = 0; i < 4; i++) w_mem[n*36 + r][4*i +: 4] = 4'(((n*7 + r*3 + i) % 5) - 2);
    end
    for (int n = 0; n < 10; n++) begin
      b_mem[8 + n] = 4'(n % 4);
      for (int h = 0; h < 2; h++)
        for (int i = 0; i < 4; i++) w_mem[288 + 2*n + h][4*i +: 4] = 4'(((n*5 + h*3 + i*2) % 13) - 6);
    end
    run(-1, 1'b0, -1, 1'b0);
    idle(2);
    run(-1, 1'b0, 500, 1'b0);
    idle(2);
    run(-1, 1'b0, -1, 1'b0);
    idle(2);
    run(-1, 1'b0, -1, 1'b1);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Control and data sequencer that drives `sigmoid_ALU` through a full two-layer inference: 8 hidden neurons over 36 four-pixel image rows, then 10 output neurons over the 8 hidden activations. It fetches image rows, weights and biases from synchronous-read memories and presents them to the ALU with the required hold time. It pulses `clear`/`accumulate`, stores hidden activations internally and reports the arg-max output neuron as the detected digit. It sits directly upstream of `sigmoid_ALU` and downstream of the image buffer and parameter ROMs.

## Interface
- N_HIDDEN, 8, hidden neurons
- N_OUTPUT, 10, output neurons
- IMG_ROWS, 36, 4-pixel rows per image
- ALU_LAT, 2, cycles operands must be stable before the accumulate cycle

- clk  in  1  clock; single clock domain, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin inference; sampled only in IDLE
- img_addr  out  6  image row index 0..35
- img_row  in  16  pixels {p4,p3,p2,p1}; lane 1 in [3:0]; valid 1 cycle after img_addr
- w_addr  out  9  hidden: n*36+row (0..287); output: 288+n*2+half (288..307)
- w_row  in  16  weights, same lane packing; valid 1 cycle after w_addr
- b_addr  out  5  0..7 hidden biases, 8..17 output biases
- b_data  in  4  bias; valid 1 cycle after b_addr
- alu_weights  out  16  to ALU weight1..4 (lane 1 = [3:0])
- alu_inputs  out  16  to ALU input1..4
- alu_bias  out  4  to ALU bias
- alu_clear  out  1  one-cycle ALU clear
- alu_accumulate  out  1  one-cycle ALU accumulate
- alu_out  in  4  ALU activation
- busy  out  1  high from start acceptance until DONE
- done  out  1  one-cycle pulse at end of inference
- digit  out  4  detected digit 0..9
- digit_valid  out  1  digit holds a valid result

## Operation
- States: IDLE, CLEAR, FETCH, LOAD, WAIT, ACCUM, CAPTURE, DONE.
- IDLE: start=1 -> CLEAR. busy=1, digit_valid=0, layer=hidden, neuron=0.
- CLEAR: alu_clear=1; b_addr = neuron (hidden) or 8+neuron (output); row=0.
- FETCH: drive img_addr=row and w_addr. In the first FETCH of each neuron, register b_data into alu_bias; alu_bias then holds for the whole neuron.
- LOAD: register w_row into alu_weights. For the hidden layer, register img_row into alu_inputs. For the output layer, alu_inputs = {h3,h2,h1,h0} when half=0 and {h7,h6,h5,h4} when half=1.
- WAIT: ALU_LAT cycles; operands held.
- ACCUM: alu_accumulate=1, operands held. Last row (35 hidden, 1 output) -> CAPTURE; otherwise row++ -> FETCH.
- CAPTURE: sample alu_out.
  - Hidden layer: store into h[neuron].
  - Output layer: if alu_out > max, set max=alu_out and idx=neuron. Ties keep the lower index; max is initialised to 0 and idx to 0 at start.
  - Next neuron -> CLEAR. After hidden neuron 7, switch to the output layer, neuron 0. After output neuron 9 -> DONE.
- DONE: done=1, digit=idx, digit_valid=1, busy=0 -> IDLE. digit and digit_valid hold until the next accepted start.
- start while busy is ignored.
- Reset, including mid-inference: next state IDLE.
  - Outputs to 0: all addresses, alu_* outputs, busy, done, digit, digit_valid.
  - Internal state to 0: h[], max, idx, counters.
  - No partial result is reported.

## Timing
- Per row: FETCH + LOAD + ALU_LAT + ACCUM = 5 cycles (ALU_LAT=2). Operands are stable for 3 cycles ending with the accumulate cycle.
- Per neuron: CLEAR 1 + rows×5 + CAPTURE 1.
  - Hidden: 182 cycles.
  - Output: 12 cycles.
- Cycle 0 is the start-sampling edge. CLEAR begins at cycle 1, and done is high in cycle 1 + 8×182 + 10×12 = 1577.
- Consecutive accumulate pulses within a neuron are exactly 5 cycles apart. Each neuron has exactly IMG_ROWS (hidden) or 2 (output) pulses.
- alu_out is sampled in CAPTURE, the cycle after the final ACCUM.
- done is high for exactly 1 cycle; busy falls in the same cycle.

## Test plan
- Bench uses a behavioural ALU matching the `sigmoid_ALU` contract and ROM models.
- All weights/biases 0 -> every alu_out 0 -> digit=0, digit_valid=1, done at cycle 1577.
- Output neuron 7 given max positive weights, all others 0 -> digit=7. Copy neuron 7's weights to neuron 3 -> tie -> digit=3.
- Address trace:
  - img_addr walks 0..35 eight times.
  - w_addr walks 0..287 then 288..307.
  - b_addr sequence is 0..17.
  - 308 accumulate pulses and 18 clear pulses in total.
- Output-layer operands: force hidden activations to 1..8 -> in output FETCH/LOAD, alu_inputs = 0x4321 for half 0 and 0x8765 for half 1.
- Assert rst at cycle 500 -> next cycle busy=0, alu_accumulate=0, addresses=0. Restart -> identical digit and identical 1577-cycle latency.
- Pulse start at cycles 10 and 1000 during a run -> ignored: exactly one done pulse, latency unchanged.
